uart_imem_loader: RTL and testbench

//  UART boot loader upstream of the pipeline CPU's instruction memory. Receives an
//  8N1 byte stream on the uart_rx pin, assembles little-endian 32-bit words and

---
 rtl/uart_imem_loader_pkg.sv | 21 ++
 rtl/uart_imem_loader_if.sv | 9 +
 rtl/uart_imem_loader_rx_byte.sv | 108 ++++++++++
 rtl/uart_imem_loader.sv | 152 +++++++++++++++
 tb/tb_uart_imem_loader.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/uart_imem_loader_pkg.sv
// Shared constants and state encodings for the UART instruction-memory boot loader.
package uart_imem_loader_pkg;

   localparam logic [7:0] LOADER_SYNC_BYTE     = 8'hA5;
   localparam int         DEFAULT_CLKS_PER_BIT = 87;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_CHK
   } loader_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the boot loader.
interface uart_imem_loader_if #(parameter int ADDR_W = 7);
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (output imem_we, imem_addr, imem_wdata);
   modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_imem_loader_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, one-cycle rx_valid / rx_frame_err.
module uart_rx_byte
   import uart_imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_frame_err
);
   localparam int               CNT_W       = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_e        state_q, state_d;
   logic [1:0]       sync_q, sync_d;
   logic             prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             rx_s;

   always_comb begin
      rx_s    = sync_q[1];
      sync_d  = {sync_q[0], uart_rx};
      prev_d  = rx_s;
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         RX_IDLE: begin
            if (prev_q && !rx_s) begin
               state_d = RX_START;
               cnt_d   = HALF_RELOAD;
            end
         end
         RX_START: begin
            if (cnt_q == '0) begin
               // a start bit that is high again at mid-bit was only a glitch
               if (rx_s) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d = RX_DATA;
                  cnt_d   = FULL_RELOAD;
                  bit_d   = 3'd0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = FULL_RELOAD;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == '0) begin
               valid_d = rx_s;
               err_d   = !rx_s;
               state_d = RX_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RX_IDLE;
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign rx_valid     = valid_q;
   assign rx_byte      = shift_q;
   assign rx_frame_err = err_q;

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: frame FSM (sync, length, data words, XOR checksum) writing instruction memory.
module uart_imem_loader
   import uart_imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
   parameter int INSTR_MEM_DEPTH = 128,
   parameter int ADDR_W          = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               uart_rx,
   uart_imem_loader_if.master imem,
   output logic               cpu_hold,
   output logic               load_done,
   output logic               load_err
);
   localparam logic [8:0] MAX_WORDS = 9'(INSTR_MEM_DEPTH);

   logic       rx_valid, rx_frame_err;
   logic [7:0] rx_byte;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk          (clk),
      .reset        (reset),
      .uart_rx      (uart_rx),
      .rx_valid     (rx_valid),
      .rx_byte      (rx_byte),
      .rx_frame_err (rx_frame_err)
   );

   loader_state_e state_q, state_d;
   logic [7:0]        n_q, n_d;
   logic [7:0]        word_cnt_q, word_cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [23:0]       shift_q, shift_d;
   logic [7:0]        chk_q, chk_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      word_cnt_d   = word_cnt_q;
      idx_d        = idx_q;
      shift_d      = shift_q;
      chk_d        = chk_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      cpu_hold_d   = cpu_hold_q;
      load_done_d  = 1'b0;
      load_err_d   = load_err_q;
      if (rx_frame_err) begin
         if (state_q != ST_IDLE) begin
            load_err_d = 1'b1;
            state_d    = ST_IDLE;
         end
      end else if (rx_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_byte == LOADER_SYNC_BYTE) begin
                  cpu_hold_d = 1'b1;
                  load_err_d = 1'b0;
                  word_cnt_d = 8'd0;
                  idx_d      = 2'd0;
                  chk_d      = 8'h00;
                  state_d    = ST_LEN;
               end
            end
            ST_LEN: begin
               n_d = rx_byte;
               if ({1'b0, rx_byte} > MAX_WORDS) begin
                  load_err_d = 1'b1;
                  state_d    = ST_IDLE;
               end else if (rx_byte == 8'd0) begin
                  state_d = ST_CHK;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               chk_d = chk_q ^ rx_byte;
               unique case (idx_q)
                  2'd0: shift_d[7:0]   = rx_byte;
                  2'd1: shift_d[15:8]  = rx_byte;
                  2'd2: shift_d[23:16] = rx_byte;
                  default: begin
                     imem_we_d    = 1'b1;
                     imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                     imem_wdata_d = {rx_byte, shift_q};
                     word_cnt_d   = word_cnt_q + 8'd1;
                     if (word_cnt_q == n_q - 8'd1) state_d = ST_CHK;
                  end
               endcase
               idx_d = idx_q + 2'd1;
            end
            ST_CHK: begin
               if (rx_byte == chk_q) begin
                  load_done_d = 1'b1;
                  cpu_hold_d  = 1'b0;
               end else begin
                  load_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         n_q          <= 8'd0;
         word_cnt_q   <= 8'd0;
         idx_q        <= 2'd0;
         shift_q      <= 24'd0;
         chk_q        <= 8'h00;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'd0;
         cpu_hold_q   <= 1'b0;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         word_cnt_q   <= word_cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         chk_q        <= chk_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         load_done_q  <= load_done_d;
         load_err_q   <= load_err_d;
      end
   end

   assign imem.imem_we    = imem_we_q;
   assign imem.imem_addr  = imem_addr_q;
   assign imem.imem_wdata = imem_wdata_q;
   assign cpu_hold        = cpu_hold_q;
   assign load_done       = load_done_q;
   assign load_err        = load_err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed frames into the UART loader; a monitor scores imem writes against a queue of expected words.
`timescale 1ns/1ps
module tb_uart_imem_loader;
   localparam int CPB    = 87;
   localparam int ADDR_W = 7;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic reset;
   logic uart_rx;
   logic cpu_hold, load_done, load_err;

   uart_imem_loader_if #(.ADDR_W(ADDR_W)) imem_bus ();

   uart_imem_loader #(
      .CLKS_PER_BIT    (CPB),
      .INSTR_MEM_DEPTH (128),
      .ADDR_W          (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .uart_rx   (uart_rx),
      .imem      (imem_bus),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_checks = 0;
   int  n_pass   = 0;
   int  done_cnt = 0;
   int  d0;
   bq_t tx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (load_done === 1'b1) done_cnt++;
         if (imem_bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write_addr", {25'd0, imem_bus.imem_addr}, 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check("write_addr", {25'd0, imem_bus.imem_addr}, {25'd0, mon_e.addr});
               check("write_data", imem_bus.imem_wdata, mon_e.data);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk) uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB / 2) @(negedge clk);
   endtask

   task automatic send_seq(input bq_t s);
      foreach (s[i]) send_byte(s[i], 1'b1);
   endtask

   task automatic check_status(input string tag, input logic hold, input logic err, input int done_delta);
      repeat (4) @(negedge clk);
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, hold});
      check({tag, "_load_err"}, {31'd0, load_err}, {31'd0, err});
      check({tag, "_load_done_pulses"}, done_cnt - d0, done_delta);
   endtask

   initial begin
      reset   = 1'b1;
      uart_rx = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_cpu_hold",  {31'd0, cpu_hold}, 32'd0);
      check("rst_load_err",  {31'd0, load_err}, 32'd0);
      check("rst_load_done", {31'd0, load_done}, 32'd0);
      check("rst_imem_we",   {31'd0, imem_bus.imem_we}, 32'd0);
      check("rst_imem_addr", {25'd0, imem_bus.imem_addr}, 32'd0);
      reset = 1'b0;
      repeat (CPB) @(negedge clk);

      // Two-word load; XOR of the eight data bytes is 0x90
      d0 = done_cnt;
      exp_q.push_back('{addr: 7'd0, data: 32'h0000_0013});
      exp_q.push_back('{addr: 7'd1, data: 32'h0010_0093});
      tx = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      send_seq(tx);
      check_status("t1_open", 1'b1, 1'b0, 0);
      send_byte(8'h90, 1'b1);
      check_status("t1_end", 1'b0, 1'b0, 1);

      // Same image, bad checksum
      d0 = done_cnt;
      exp_q.push_back('{addr: 7'd0, data: 32'h0000_0013});
      exp_q.push_back('{addr: 7'd1, data: 32'h0010_0093});
      tx = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
      send_seq(tx);
      check_status("t2", 1'b1, 1'b1, 0);

      // N = 129 rejected
      d0 = done_cnt;
      tx = '{8'hA5, 8'h81};
      send_seq(tx);
      check_status("t3", 1'b1, 1'b1, 0);

      // Junk before sync, then a glitch while waiting for N
      d0 = done_cnt;
      tx = '{8'h55, 8'hFF};
      send_seq(tx);
      check_status("t4_junk", 1'b1, 1'b1, 0);
      send_byte(8'hA5, 1'b1);
      check_status("t4_sync", 1'b1, 1'b0, 0);
      @(negedge clk) uart_rx = 1'b0;
      repeat (CPB * 3 / 10) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      exp_q.push_back('{addr: 7'd0, data: 32'hDEAD_BEEF});
      tx = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      send_seq(tx);
      check_status("t4_end", 1'b0, 1'b0, 1);

      // Framing error on the third data byte
      d0 = done_cnt;
      tx = '{8'hA5, 8'h01, 8'h11, 8'h22};
      send_seq(tx);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b1);
      check_status("t5", 1'b1, 1'b1, 0);

      // Zero-length load only completes if the framing error returned the FSM to IDLE
      d0 = done_cnt;
      tx = '{8'hA5, 8'h00, 8'h00};
      send_seq(tx);
      check_status("t5_n0", 1'b0, 1'b0, 1);

      // Reset during word 1 of a 4-word load
      d0 = done_cnt;
      exp_q.push_back('{addr: 7'd0, data: 32'h0403_0201});
      tx = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_seq(tx);
      check_status("t6_open", 1'b1, 1'b0, 0);
      @(negedge clk) reset = 1'b1;
      #1;
      check("t6_rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      check("t6_rst_load_err", {31'd0, load_err}, 32'd0);
      check("t6_rst_imem_we",  {31'd0, imem_bus.imem_we}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (CPB) @(negedge clk);
      d0 = done_cnt;
      exp_q.push_back('{addr: 7'd0, data: 32'h1234_5678});
      tx = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      send_seq(tx);
      check_status("t6_end", 1'b0, 1'b0, 1);

      check("writes_outstanding", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
